hififo_fpc_reorder: RTL
=======================

HIFIFO_FPC_REORDER -- requirements
Module: hififo_fpc_reorder

Interface
REQ-001 Parameter CHANNEL, default 0: 4-bit channel id, matched against rc_tag[7:4] and driven on rr_tag[7:4].
REQ-002 Parameter SLOTS_LOG2, default 3: reorder depth is 2**SLOTS_LOG2 blocks, range 1..4.
REQ-003 Parameter WORDS_LOG2, default 6: block is 2**WORDS_LOG2 64-bit words, range 4..7 (block bytes = 8<<WORDS_LOG2).
REQ-004 Parameter MAX_OUTSTANDING, default 2**SLOTS_LOG2 - 2: read-request limit, range 1..2**SLOTS_LOG2.
REQ-005 clock  in  1  single clock for all signals.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 desc_valid/desc_ready  in/out  1/1  transfer descriptor handshake.
REQ-008 desc_addr  in  64  start byte address; low WORDS_LOG2+3 bits ignored (treated as zero).
REQ-009 desc_blocks  in  16  block count of transfer.
REQ-010 rr_valid/rr_ready  out/in  1/1  read-request handshake; rr_addr out 64; rr_tag out 8 = {CHANNEL, 0-padded slot}.
REQ-011 rc_valid  in  1; rc_tag  in  8; rc_index  in  WORDS_LOG2 (word within block); rc_data  in  64.
REQ-012 o_valid/o_ready  out/in  1/1; o_data  out  64  in-order output stream.
REQ-013 done  out  1  one-cycle completion pulse; busy  out  1; blocks_done  out  32  running count; tag_err  out  1  sticky.

Function
REQ-014 States IDLE, RUN, DRAIN; desc_ready = 1 only in IDLE; handshake in IDLE -> RUN, latching address and count.
REQ-015 desc_blocks = 0: descriptor accepted, no requests, done pulses next cycle, state stays IDLE.
REQ-016 RUN: rr_valid = 1 while remaining > 0 and outstanding < MAX_OUTSTANDING; rr_addr, rr_tag stable until rr_ready.
REQ-017 On rr handshake: slot p_req allocated, rr_addr += block bytes (64-bit modular wrap), remaining -= 1, p_req += 1 mod slots.
REQ-018 remaining reaching 0 -> DRAIN; DRAIN -> IDLE with done pulse when last slot's last word accepted at output.
REQ-019 Outstanding = allocated slots not yet fully drained; allocate and free in same cycle leave it unchanged.
REQ-020 Completion accepted when rc_valid and rc_tag[7:4] == CHANNEL and addressed slot allocated and not filled; data written to buffer at {slot, rc_index}.
REQ-021 Slot marked filled when accepted word has rc_index = all ones; per-request completions arrive in index order.
REQ-022 Completion with matching channel to unallocated or filled slot: discarded, tag_err set; non-matching channel ignored silently.
REQ-023 Drain: words of slot p_drain output in index order only once that slot filled; slots drained strictly in allocation order.
REQ-024 Buffer read latency 1 cycle; output register plus skid so o_valid holds under o_ready = 0 with no loss, duplication or bubble when o_ready held 1 (1 word/cycle sustained).
REQ-025 o_data stable while o_valid & ~o_ready.
REQ-026 Slot freed and blocks_done += 1 (32-bit wrap) on acceptance of its last word.
REQ-027 busy = state != IDLE.
REQ-028 Simultaneous completion write to slot A and drain read of slot B allowed every cycle.

Reset
REQ-029 reset: state IDLE, all slots unallocated/unfilled, pointers 0, rr_valid 0, o_valid 0, done 0, blocks_done 0, tag_err 0, desc_ready 1 next cycle.
REQ-030 Reset mid-transfer discards buffered data; completions arriving afterward flag tag_err and are discarded.

Verification
REQ-031 Defaults, desc_addr 0x1000, desc_blocks 3, completions in order, o_ready 1 -> rr_addr 0x1000/0x1200/0x1400, tags 0x00/0x01/0x02, 192 words in order, one done pulse, blocks_done 3.
REQ-032 Defaults, desc_blocks 4, slot 1 completes before slot 0 -> no output until slot 0 full, then slot0 then slot1 words.
REQ-033 desc_blocks 20, rr_ready always 1, completions delayed -> never more than 6 requests outstanding; slot tags wrap 7 -> 0.
REQ-034 o_ready toggled randomly over 8 blocks -> scoreboard exact data, no drops/duplicates.
REQ-035 Completion with tag {CHANNEL, unallocated slot} -> discarded, tag_err = 1; foreign channel -> ignored, tag_err unchanged.
REQ-036 reset asserted mid-block -> all outputs at reset values next cycle; fresh descriptor then completes correctly.

Source files
------------

// File: rtl/hififo_fpc_reorder_if.sv
// Reorder-engine bus: descriptor in, read requests out, tagged completions in, ordered stream out.
// The master modport is the requester/host side and the slave modport is the reorder engine.
interface hififo_fpc_reorder_if #(
    parameter int WORDS_LOG2 = 6
);
    logic                  desc_valid;
    logic                  desc_ready;
    logic [63:0]           desc_addr;
    logic [15:0]           desc_blocks;

    logic                  rr_valid;
    logic                  rr_ready;
    logic [63:0]           rr_addr;
    logic [7:0]            rr_tag;

    logic                  rc_valid;
    logic [7:0]            rc_tag;
    logic [WORDS_LOG2-1:0] rc_index;
    logic [63:0]           rc_data;

    logic                  o_valid;
    logic                  o_ready;
    logic [63:0]           o_data;

    modport master (
        output desc_valid, desc_addr, desc_blocks, rr_ready,
        output rc_valid, rc_tag, rc_index, rc_data, o_ready,
        input  desc_ready, rr_valid, rr_addr, rr_tag, o_valid, o_data
    );

    modport slave (
        input  desc_valid, desc_addr, desc_blocks, rr_ready,
        input  rc_valid, rc_tag, rc_index, rc_data, o_ready,
        output desc_ready, rr_valid, rr_addr, rr_tag, o_valid, o_data
    );
endinterface

// File: rtl/hififo_fpc_reorder.sv
// Block read engine: issues tagged block reads, gathers out-of-order completions, emits words in request order.
// Output is 2 cycles after a slot fills (buffer read + output reg); a 2-entry skid keeps 1 word/cycle under o_ready backpressure.
module hififo_fpc_reorder #(
    parameter int CHANNEL         = 0,
    parameter int SLOTS_LOG2      = 3,
    parameter int WORDS_LOG2      = 6,
    parameter int MAX_OUTSTANDING = 2**SLOTS_LOG2 - 2
) (
    input  logic                 clk,
    input  logic                 reset,
    hififo_fpc_reorder_if.slave  bus,
    output logic                 done,
    output logic                 busy,
    output logic [31:0]          blocks_done,
    output logic                 tag_err
);
    localparam int SLOTS = 1 << SLOTS_LOG2;
    localparam int WORDS = 1 << WORDS_LOG2;
    localparam int OFF   = WORDS_LOG2 + 3;
    localparam logic [63:0] BLK_BYTES = 64'd8 << WORDS_LOG2;
    localparam logic [63:0] ADDR_MASK = ~((64'd1 << OFF) - 64'd1);
    localparam logic [3:0]  CH        = 4'(CHANNEL);
    localparam logic [SLOTS_LOG2:0] MAX_OUT = (SLOTS_LOG2+1)'(MAX_OUTSTANDING);
    localparam logic [SLOTS_LOG2:0] ONE     = (SLOTS_LOG2+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [63:0]           req_addr;
    logic [15:0]           remaining;
    logic [SLOTS_LOG2-1:0] p_req, p_rd, p_drain;
    logic [SLOTS-1:0]      alloc, filled;
    logic [SLOTS_LOG2:0]   outstanding, unread;
    logic [WORDS_LOG2-1:0] rd_idx;

    logic [63:0]           mem [SLOTS*WORDS];
    logic                  rd_pend, rd_last;
    logic [63:0]           rd_dat;

    logic [1:0]            ocnt;
    logic [63:0]           q0, q1;
    logic                  q0_last, q1_last;

    logic                  desc_fire, rr_fire;
    logic                  rc_ch_ok, rc_slot_ok, rc_accept, rc_bad, rc_last;
    logic [SLOTS_LOG2-1:0] rc_slot;
    logic [3:0]            rc_hi;
    logic                  pop, free, rd_go, rd_slot_end;
    logic [2:0]            lvl;

    assign bus.desc_ready = (state == S_IDLE);
    assign desc_fire      = bus.desc_valid & bus.desc_ready;

    assign bus.rr_valid = (state == S_RUN) && (remaining != 16'd0) && (outstanding < MAX_OUT);
    assign bus.rr_addr  = req_addr;
    assign bus.rr_tag   = {CH, 4'(p_req)};
    assign rr_fire      = bus.rr_valid & bus.rr_ready;

    // Tag bits above the slot field must be zero, otherwise the tag names no slot.
    assign rc_slot    = bus.rc_tag[SLOTS_LOG2-1:0];
    assign rc_hi      = bus.rc_tag[3:0] >> SLOTS_LOG2;
    assign rc_slot_ok = (rc_hi == 4'd0);
    assign rc_ch_ok   = bus.rc_valid && (bus.rc_tag[7:4] == CH);
    assign rc_accept  = rc_ch_ok && rc_slot_ok && alloc[rc_slot] && !filled[rc_slot];
    assign rc_bad     = rc_ch_ok && !rc_accept;
    assign rc_last    = &bus.rc_index;

    // Reads are issued only when the word in flight is guaranteed a place in the skid.
    assign pop         = (ocnt != 2'd0) && bus.o_ready;
    assign lvl         = {1'b0, ocnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign rd_go       = (unread != '0) && filled[p_rd] && (lvl <= 3'd1);
    assign rd_slot_end = rd_go && (&rd_idx);
    assign free        = pop && q0_last;

    assign bus.o_valid = (ocnt != 2'd0);
    assign bus.o_data  = q0;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rc_accept) mem[{rc_slot, bus.rc_index}] <= bus.rc_data;
        rd_dat <= mem[{p_rd, rd_idx}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            req_addr    <= '0;
            remaining   <= '0;
            p_req       <= '0;
            p_rd        <= '0;
            p_drain     <= '0;
            alloc       <= '0;
            filled      <= '0;
            outstanding <= '0;
            unread      <= '0;
            rd_idx      <= '0;
            rd_pend     <= 1'b0;
            rd_last     <= 1'b0;
            ocnt        <= 2'd0;
            q0          <= '0;
            q1          <= '0;
            q0_last     <= 1'b0;
            q1_last     <= 1'b0;
            done        <= 1'b0;
            blocks_done <= '0;
            tag_err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (desc_fire) begin
                    if (bus.desc_blocks == 16'd0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= S_RUN;
                        req_addr  <= bus.desc_addr & ADDR_MASK;
                        remaining <= bus.desc_blocks;
                    end
                end
                S_RUN: if (rr_fire) begin
                    req_addr  <= req_addr + BLK_BYTES;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) state <= S_DRAIN;
                end
                S_DRAIN: if (free && outstanding == ONE) begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            // Free before allocate so a slot recycled in the same cycle ends up allocated.
            if (free) begin
                alloc[p_drain]  <= 1'b0;
                filled[p_drain] <= 1'b0;
                p_drain         <= p_drain + 1'b1;
                blocks_done     <= blocks_done + 32'd1;
            end
            if (rr_fire) begin
                alloc[p_req] <= 1'b1;
                p_req        <= p_req + 1'b1;
            end
            if (rc_accept && rc_last) filled[rc_slot] <= 1'b1;
            if (rc_bad) tag_err <= 1'b1;

            case ({rr_fire, free})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: outstanding <= outstanding;
            endcase
            case ({rr_fire, rd_slot_end})
                2'b10:   unread <= unread + ONE;
                2'b01:   unread <= unread - ONE;
                default: unread <= unread;
            endcase

            if (rd_go) begin
                rd_idx <= rd_idx + 1'b1;
                if (&rd_idx) p_rd <= p_rd + 1'b1;
            end
            rd_pend <= rd_go;
            rd_last <= rd_slot_end;

            case ({rd_pend, pop})
                2'b10: begin
                    if (ocnt == 2'd0) begin
                        q0      <= rd_dat;
                        q0_last <= rd_last;
                    end else begin
                        q1      <= rd_dat;
                        q1_last <= rd_last;
                    end
                    ocnt <= ocnt + 2'd1;
                end
                2'b01: begin
                    q0      <= q1;
                    q0_last <= q1_last;
                    ocnt    <= ocnt - 2'd1;
                end
                2'b11: begin
                    if (ocnt == 2'd1) begin
                        q0      <= rd_dat;
                        q0_last <= rd_last;
                    end else begin
                        q0      <= q1;
                        q0_last <= q1_last;
                        q1      <= rd_dat;
                        q1_last <= rd_last;
                    end
                end
                default: ocnt <= ocnt;
            endcase
        end
    end
endmodule
